ysyx_22050019_lsu_axi: RTL and testbench



---
 rtl/ysyx_22050019_lsu_pkg.sv | 53 +++++
 rtl/ysyx_22050019_lsu_axi_if.sv | 39 +++
 rtl/ysyx_22050019_lsu_align.sv | 56 +++++
 rtl/ysyx_22050019_lsu_axi.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22050019_lsu_axi.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared constants for the multi-cycle load/store unit: FSM states, one-hot width codes,
// AXI response codes and byte-offset helpers.
package ysyx_22050019_lsu_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [5:0] R_LW  = 6'b100000;
  localparam logic [5:0] R_LH  = 6'b010000;
  localparam logic [5:0] R_LB  = 6'b001000;
  localparam logic [5:0] R_LWU = 6'b000100;
  localparam logic [5:0] R_LHU = 6'b000010;
  localparam logic [5:0] R_LBU = 6'b000001;

  localparam logic [3:0] W_SD = 4'b1000;
  localparam logic [3:0] W_SB = 4'b0100;
  localparam logic [3:0] W_SH = 4'b0010;
  localparam logic [3:0] W_SW = 4'b0001;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Low address bits that must be zero for a naturally aligned access of the given width.
  function automatic logic [2:0] size_mask(input logic is_load, input logic [5:0] r_wdth,
                                           input logic [3:0] w_wdth);
    logic [2:0] m;
    m = 3'b111;
    if (is_load) begin
      case (r_wdth)
        R_LW, R_LWU: m = 3'b011;
        R_LH, R_LHU: m = 3'b001;
        R_LB, R_LBU: m = 3'b000;
        default:     m = 3'b111;
      endcase
    end else begin
      case (w_wdth)
        W_SW:    m = 3'b011;
        W_SH:    m = 3'b001;
        W_SB:    m = 3'b000;
        default: m = 3'b111;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_axi_if.sv
// AXI4-Lite-style bus between the LSU (master) and memory (slave).
interface ysyx_22050019_lsu_axi_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  modport slave (
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );
endinterface

// File: rtl/ysyx_22050019_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with sign/zero extension.
module ysyx_22050019_lsu_align
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int OFF_W  = off_w(DATA_W),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        st_wdth,
  input  logic [OFF_W-1:0]  st_off,
  output logic [DATA_W-1:0] st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  input  logic [DATA_W-1:0] ld_raw,
  input  logic [5:0]        ld_wdth,
  input  logic [OFF_W-1:0]  ld_off,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input logic [5:0] w);
    logic signed [31:0] s32;
    logic signed [15:0] s16;
    logic signed [7:0]  s8;
    s32 = v[31:0];
    s16 = v[15:0];
    s8  = v[7:0];
    case (w)
      R_LW:    return DATA_W'(s32);
      R_LH:    return DATA_W'(s16);
      R_LB:    return DATA_W'(s8);
      R_LWU:   return DATA_W'(v[31:0]);
      R_LHU:   return DATA_W'(v[15:0]);
      R_LBU:   return DATA_W'(v[7:0]);
      default: return v;
    endcase
  endfunction

  logic [STRB_W-1:0] base_mask;
  logic [DATA_W-1:0] ld_shift;

  // Lanes shifted past the top of the bus are simply dropped.
  always_comb begin
    case (st_wdth)
      W_SD:    base_mask = '1;
      W_SW:    base_mask = STRB_W'(4'hF);
      W_SH:    base_mask = STRB_W'(4'h3);
      W_SB:    base_mask = STRB_W'(4'h1);
      default: base_mask = '1;
    endcase
    st_wstrb = base_mask << st_off;
    st_wdata = st_data << {st_off, 3'b000};
    ld_shift = ld_raw >> {ld_off, 3'b000};
    ld_data  = extend(ld_shift, ld_wdth);
  end

endmodule

// File: rtl/ysyx_22050019_lsu_axi.sv
// Multi-cycle load/store unit: one EX request at a time over an AXI4-Lite-style master.
// Optional YSYX_22050019_LSU_MISALIGN_CHECK_EN rejects misaligned accesses without bus traffic.
module ysyx_22050019_lsu_axi
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [5:0]        req_r_wdth,
  input  logic [3:0]        req_w_wdth,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [RD_W-1:0]   wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_err,
  ysyx_22050019_lsu_axi_if.master axi
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int STRB_W = DATA_W / 8;

  logic [2:0]        state;
  logic              is_load;
  logic              err_q;
  logic              aw_done;
  logic              w_done;
  logic [RD_W-1:0]   rd_q;
  logic [5:0]        r_wdth_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] ld_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] addr_al;
  logic [DATA_W-1:0] st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [DATA_W-1:0] ld_data;
  logic              wide_bad;
  logic              misalign;
  logic              acc_err;
  logic              aw_vld;
  logic              w_vld;
  logic              aw_hs;
  logic              w_hs;

  assign req_off = req_addr[OFF_W-1:0];
  assign addr_al = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // A doubleword access cannot be carried by a 32-bit bus.
  assign wide_bad = (DATA_W == 32) &&
                    ((req_we && (req_w_wdth == W_SD)) || (req_re && !$onehot(req_r_wdth)));

`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
  assign misalign = |(3'(req_off) & size_mask(req_re, req_r_wdth, req_w_wdth));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = (req_re && req_we) || wide_bad || misalign;

  ysyx_22050019_lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_data  (req_wdata),
    .st_wdth  (req_w_wdth),
    .st_off   (req_off),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_raw   (axi.m_rdata),
    .ld_wdth  (r_wdth_q),
    .ld_off   (off_q),
    .ld_data  (ld_data)
  );

  assign aw_vld = (state == ST_WR_REQ) && !aw_done;
  assign w_vld  = (state == ST_WR_REQ) && !w_done;
  assign aw_hs  = aw_vld && axi.m_awready;
  assign w_hs   = w_vld && axi.m_wready;

  assign req_ready     = (state == ST_IDLE);
  assign axi.m_arvalid = (state == ST_RD_ADDR);
  assign axi.m_araddr  = araddr_q;
  assign axi.m_rready  = (state == ST_RD_DATA);
  assign axi.m_awvalid = aw_vld;
  assign axi.m_awaddr  = awaddr_q;
  assign axi.m_wvalid  = w_vld;
  assign axi.m_wdata   = wdata_q;
  assign axi.m_wstrb   = wstrb_q;
  assign axi.m_bready  = (state == ST_WR_RESP);

  assign wb_valid = (state == ST_DONE);
  assign wb_wen   = wb_valid && is_load && !err_q;
  assign wb_err   = wb_valid && err_q;
  assign wb_waddr = rd_q;
  assign wb_wdata = wb_wen ? ld_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      is_load  <= 1'b0;
      err_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_q     <= '0;
      r_wdth_q <= '0;
      off_q    <= '0;
      ld_q     <= '0;
      araddr_q <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rd_q     <= req_rd;
            r_wdth_q <= req_r_wdth;
            off_q    <= req_off;
            is_load  <= req_re && !req_we;
            err_q    <= acc_err;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            if (req_re) araddr_q <= addr_al;
            if (req_we) begin
              awaddr_q <= addr_al;
              wdata_q  <= st_wdata;
              wstrb_q  <= st_wstrb;
            end
            if (acc_err || (!req_re && !req_we)) state <= ST_DONE;
            else if (req_re)                     state <= ST_RD_ADDR;
            else                                 state <= ST_WR_REQ;
          end
        end
        ST_RD_ADDR: if (axi.m_arready) state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (axi.m_rvalid) begin
            ld_q  <= ld_data;
            err_q <= (axi.m_rresp != RESP_OKAY);
            state <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently; leave only when both have handshaken.
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (axi.m_bvalid) begin
            err_q <= (axi.m_bresp != RESP_OKAY);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_lsu_axi.sv
// Directed bench for the multi-cycle LSU with a hand-driven AXI slave.
module tb_ysyx_22050019_lsu_axi;
  import ysyx_22050019_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_we;
  logic        req_re;
  logic [5:0]  req_r_wdth;
  logic [3:0]  req_w_wdth;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        wb_err;

  int n_chk;
  int n_fail;

  ysyx_22050019_lsu_axi_if #(.ADDR_W(64), .DATA_W(64)) axi ();

  ysyx_22050019_lsu_axi #(.DATA_W(64), .ADDR_W(64), .RD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_re     (req_re),
    .req_r_wdth (req_r_wdth),
    .req_w_wdth (req_w_wdth),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .wb_valid   (wb_valid),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_err     (wb_err),
    .axi        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic drive_req(input logic re, input logic we, input logic [63:0] addr,
                           input logic [5:0] rw, input logic [3:0] ww,
                           input logic [63:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_re     = re;
    req_we     = we;
    req_addr   = addr;
    req_r_wdth = rw;
    req_w_wdth = ww;
    req_wdata  = wdata;
    req_rd     = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_re    = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [63:0] addr, input logic [5:0] rw,
                          input logic [63:0] rdata, input logic [1:0] rresp,
                          input logic [4:0] rd, input logic [63:0] exp_data,
                          input logic exp_err);
    wait_idle(tag);
    drive_req(1'b1, 1'b0, addr, rw, 4'b0, 64'h0, rd);
    chk({tag, "_arvalid"}, axi.m_arvalid, 1);
    chk({tag, "_araddr"}, axi.m_araddr, addr & ~64'h7);
    axi.m_arready = 1'b1;
    @(negedge clk);
    axi.m_arready = 1'b0;
    chk({tag, "_rready"}, axi.m_rready, 1);
    axi.m_rvalid = 1'b1;
    axi.m_rdata  = rdata;
    axi.m_rresp  = rresp;
    @(negedge clk);
    axi.m_rvalid = 1'b0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_wen"}, wb_wen, !exp_err);
    chk({tag, "_wb_err"}, wb_err, exp_err);
    chk({tag, "_wb_waddr"}, wb_waddr, rd);
    chk({tag, "_wb_wdata"}, wb_wdata, exp_data);
    @(negedge clk);
    chk({tag, "_wb_pulse"}, wb_valid, 0);
  endtask

  task automatic run_store(input string tag, input logic [63:0] addr, input logic [3:0] ww,
                           input logic [63:0] wdata, input logic [1:0] bresp,
                           input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
    wait_idle(tag);
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    drive_req(1'b0, 1'b1, addr, 6'b0, ww, wdata, 5'd0);
    chk({tag, "_awvalid"}, axi.m_awvalid, 1);
    chk({tag, "_wvalid"}, axi.m_wvalid, 1);
    chk({tag, "_awaddr"}, axi.m_awaddr, addr & ~64'h7);
    chk({tag, "_wdata"}, axi.m_wdata, exp_wdata);
    chk({tag, "_wstrb"}, axi.m_wstrb, exp_wstrb);
    @(negedge clk);
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    chk({tag, "_bready"}, axi.m_bready, 1);
    chk({tag, "_aw_drop"}, axi.m_awvalid, 0);
    axi.m_bvalid = 1'b1;
    axi.m_bresp  = bresp;
    @(negedge clk);
    axi.m_bvalid = 1'b0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_wen"}, wb_wen, 0);
    chk({tag, "_wb_err"}, wb_err, bresp != 2'b00);
    @(negedge clk);
    chk({tag, "_wb_pulse"}, wb_valid, 0);
  endtask

  task automatic run_nobus(input string tag, input logic re, input logic we,
                           input logic [63:0] addr, input logic [5:0] rw,
                           input logic [3:0] ww, input logic exp_err);
    wait_idle(tag);
    drive_req(re, we, addr, rw, ww, 64'h0, 5'd3);
    chk({tag, "_arvalid"}, axi.m_arvalid, 0);
    chk({tag, "_awvalid"}, axi.m_awvalid, 0);
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_wen"}, wb_wen, 0);
    chk({tag, "_wb_err"}, wb_err, exp_err);
    @(negedge clk);
    chk({tag, "_wb_pulse"}, wb_valid, 0);
  endtask

  initial begin
    int aw_cnt;
    int w_cnt;
    logic saw_wb;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0; req_addr = '0;
    req_r_wdth = '0; req_w_wdth = '0; req_wdata = '0; req_rd = '0;
    axi.m_arready = 1'b0; axi.m_rdata = '0; axi.m_rresp = '0; axi.m_rvalid = 1'b0;
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bresp = '0; axi.m_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", axi.m_arvalid, 0);
    chk("rst_awvalid", axi.m_awvalid, 0);
    chk("rst_wvalid", axi.m_wvalid, 0);
    chk("rst_rready", axi.m_rready, 0);
    chk("rst_bready", axi.m_bready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_araddr", axi.m_araddr, 0);
    chk("rst_wstrb", axi.m_wstrb, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    run_store("sb", 64'h8000_0003, W_SB, 64'hAB, 2'b00, 64'h0000_0000_AB00_0000, 8'h08);
    run_store("sd", 64'h8000_0008, W_SD, 64'h1122_3344_5566_7788, 2'b00,
              64'h1122_3344_5566_7788, 8'hFF);
    run_store("sh", 64'h8000_0006, W_SH, 64'hBEEF, 2'b00, 64'hBEEF_0000_0000_0000, 8'hC0);
    run_store("sw_berr", 64'h8000_0000, W_SW, 64'hCAFE_F00D, 2'b11,
              64'h0000_0000_CAFE_F00D, 8'h0F);

    run_load("lb", 64'h8000_0005, R_LB, 64'h0000_8000_0000_0000, 2'b00, 5'd7,
             64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    run_load("lbu", 64'h8000_0005, R_LBU, 64'h0000_8000_0000_0000, 2'b00, 5'd8,
             64'h0000_0000_0000_0080, 1'b0);
    run_load("lw", 64'h8000_0004, R_LW, 64'h8765_4321_0000_0000, 2'b00, 5'd9,
             64'hFFFF_FFFF_8765_4321, 1'b0);
    run_load("lwu", 64'h8000_0004, R_LWU, 64'h8765_4321_0000_0000, 2'b00, 5'd10,
             64'h0000_0000_8765_4321, 1'b0);
    run_load("lh", 64'h8000_0002, R_LH, 64'h0000_0000_F00D_0000, 2'b00, 5'd11,
             64'hFFFF_FFFF_FFFF_F00D, 1'b0);
    run_load("lhu", 64'h8000_0002, R_LHU, 64'h0000_0000_F00D_0000, 2'b00, 5'd12,
             64'h0000_0000_0000_F00D, 1'b0);
    run_load("ld_dflt", 64'h8000_0000, 6'b000000, 64'h0123_4567_89AB_CDEF, 2'b00, 5'd13,
             64'h0123_4567_89AB_CDEF, 1'b0);
    run_load("lw_rerr", 64'h8000_0000, R_LW, 64'hDEAD_BEEF, 2'b10, 5'd14, 64'h0, 1'b1);

`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
    run_nobus("lw_mis", 1'b1, 1'b0, 64'h8000_0002, R_LW, 4'b0, 1'b1);
`else
    run_load("lw_mis", 64'h8000_0002, R_LW, 64'h1111_2222_3333_4444, 2'b00, 5'd15,
             64'h0000_0000_2222_3333, 1'b0);
`endif

    run_nobus("none", 1'b0, 1'b0, 64'h8000_0000, 6'b0, 4'b0, 1'b0);
    run_nobus("both", 1'b1, 1'b1, 64'h8000_0000, R_LW, W_SW, 1'b1);

    // sw: W accepted at once, AW held off for three extra cycles
    wait_idle("sw_dly");
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b1;
    drive_req(1'b0, 1'b1, 64'h8000_0004, 6'b0, W_SW, 64'h1234_5678, 5'd0);
    chk("sw_dly_wdata", axi.m_wdata, 64'h1234_5678_0000_0000);
    chk("sw_dly_wstrb", axi.m_wstrb, 8'hF0);
    aw_cnt = 0;
    w_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (axi.m_bready) break;
      if (axi.m_awvalid) aw_cnt++;
      if (axi.m_wvalid) w_cnt++;
      axi.m_awready = (aw_cnt >= 4);
      @(negedge clk);
    end
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    chk("sw_dly_aw_cycles", aw_cnt, 4);
    chk("sw_dly_w_cycles", w_cnt, 1);
    chk("sw_dly_bready", axi.m_bready, 1);
    axi.m_bvalid = 1'b1;
    axi.m_bresp  = 2'b00;
    @(negedge clk);
    axi.m_bvalid = 1'b0;
    chk("sw_dly_wb_valid", wb_valid, 1);
    chk("sw_dly_wb_err", wb_err, 0);

    // asynchronous reset while waiting on R
    wait_idle("rst_mid");
    drive_req(1'b1, 1'b0, 64'h8000_0000, R_LW, 4'b0, 64'h0, 5'd5);
    axi.m_arready = 1'b1;
    @(negedge clk);
    axi.m_arready = 1'b0;
    chk("rst_mid_rready_pre", axi.m_rready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rready", axi.m_rready, 0);
    chk("rst_mid_arvalid", axi.m_arvalid, 0);
    chk("rst_mid_awvalid", axi.m_awvalid, 0);
    chk("rst_mid_wvalid", axi.m_wvalid, 0);
    chk("rst_mid_wb_valid", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_wb = saw_wb | wb_valid;
    end
    chk("rst_mid_no_wb", saw_wb, 0);
    chk("rst_mid_req_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
